// File: rtl/branch_target_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating counters for the IF stage.
// Optional statistics counters are enabled by defining BTP_STATS_EN.
module branch_target_predictor #(
    parameter int unsigned ADDR_WIDTH   = 64,
    parameter int unsigned ENTRIES      = 16,
    parameter logic [1:0]  COUNTER_INIT = 2'b01
) (
    input  logic                  CLOCK,
    input  logic                  RESET,
    input  logic [ADDR_WIDTH-1:0] lookup_pc,
    output logic                  predict_hit,
    output logic                  predict_taken,
    output logic [ADDR_WIDTH-1:0] predict_target,
    input  logic                  update_valid,
    input  logic [ADDR_WIDTH-1:0] update_pc,
    input  logic                  update_taken,
    input  logic [ADDR_WIDTH-1:0] update_target,
    input  logic                  update_pred_taken,
    input  logic [ADDR_WIDTH-1:0] update_pred_target,
    output logic                  mispredict
`ifdef BTP_STATS_EN
    ,
    output logic [31:0]           stat_updates,
    output logic [31:0]           stat_mispredicts
`endif
);

    localparam int unsigned IDX      = $clog2(ENTRIES);
    localparam int unsigned TAG_W    = ADDR_WIDTH - IDX - 2;
    localparam logic [1:0]  CTR_WEAK_TAKEN = 2'b10;

    logic [ENTRIES-1:0]    validQ;
    logic [1:0]            ctrQ    [ENTRIES];
    logic [TAG_W-1:0]      tagQ    [ENTRIES];
    logic [ADDR_WIDTH-1:0] targetQ [ENTRIES];

    logic [IDX-1:0]        lookupIdx;
    logic [TAG_W-1:0]      lookupTag;
    logic [IDX-1:0]        updIdx;
    logic [TAG_W-1:0]      updTag;
    logic                  updHit;
    logic [1:0]            updCtrNext;
    logic                  mispredictC;
    logic [3:0]            unusedPcBits;

    assign lookupIdx    = lookup_pc[IDX+1:2];
    assign lookupTag    = lookup_pc[ADDR_WIDTH-1:IDX+2];
    assign updIdx       = update_pc[IDX+1:2];
    assign updTag       = update_pc[ADDR_WIDTH-1:IDX+2];
    assign unusedPcBits = {lookup_pc[1:0], update_pc[1:0]};

    // Zero-latency lookup; reset masks any stale entries still held this cycle.
    always_comb begin
        predict_hit    = 1'b0;
        predict_taken  = 1'b0;
        predict_target = lookup_pc + ADDR_WIDTH'(4);
        if (!RESET && validQ[lookupIdx] && (tagQ[lookupIdx] == lookupTag)) begin
            predict_hit = 1'b1;
            if (ctrQ[lookupIdx][1]) begin
                predict_taken  = 1'b1;
                predict_target = targetQ[lookupIdx];
            end
        end
    end

    // Saturating counter step and misprediction detection for the resolving branch.
    always_comb begin
        updHit     = validQ[updIdx] && (tagQ[updIdx] == updTag);
        updCtrNext = ctrQ[updIdx];
        if (update_taken) begin
            if (ctrQ[updIdx] != 2'b11) begin
                updCtrNext = ctrQ[updIdx] + 2'd1;
            end
        end else begin
            if (ctrQ[updIdx] != 2'b00) begin
                updCtrNext = ctrQ[updIdx] - 2'd1;
            end
        end
        mispredictC = (update_taken != update_pred_taken) ||
                      (update_taken && update_pred_taken &&
                       (update_target != update_pred_target));
    end

    // Valid bits, counters and the mispredict pulse; reset wins over any update.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            validQ     <= '0;
            mispredict <= 1'b0;
            for (int i = 0; i < int'(ENTRIES); i++) begin
                ctrQ[i] <= COUNTER_INIT;
            end
        end else begin
            mispredict <= update_valid && mispredictC;
            if (update_valid) begin
                if (updHit) begin
                    ctrQ[updIdx] <= updCtrNext;
                end else if (update_taken) begin
                    validQ[updIdx] <= 1'b1;
                    ctrQ[updIdx]   <= CTR_WEAK_TAKEN;
                end
            end
        end
    end

    // Tag/target storage carries no reset; valid bits qualify it.
    always_ff @(posedge CLOCK) begin
        if (!RESET && update_valid && update_taken) begin
            tagQ[updIdx]    <= updTag;
            targetQ[updIdx] <= update_target;
        end
    end

`ifdef BTP_STATS_EN
    // Saturating event counters.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            stat_updates     <= '0;
            stat_mispredicts <= '0;
        end else begin
            if (update_valid && (stat_updates != 32'hFFFF_FFFF)) begin
                stat_updates <= stat_updates + 32'd1;
            end
            if (mispredict && (stat_mispredicts != 32'hFFFF_FFFF)) begin
                stat_mispredicts <= stat_mispredicts + 32'd1;
            end
        end
    end
`endif

endmodule
